// File: rtl/fixed_point_pkg.sv
// Shared definitions for the fixed-point divider and its dispatcher.
// Holds the default word width, the dispatcher state encoding and the status constants.
package fixed_point_pkg;

    localparam int WIDTH_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    localparam logic [WIDTH_DEFAULT-1:0] ZERO_RESULT = '0;
    localparam logic                     OVF_SET     = 1'b1;

endpackage

// File: rtl/operand_fifo.sv
// Operand FIFO with wrap-around pointers, occupancy count and a registered ready.
// A push is only taken while ready is high; pushes offered while full are dropped.
module operand_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     ready,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] LVL_FULL = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      level_next;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && ready;
    assign do_pop  = pop && (level != '0);
    assign rdata   = mem[rd_ptr];

    always_comb begin
        level_next = level;
        if (do_push && !do_pop) begin
            level_next = level + (PW+1)'(1);
        end else if (!do_push && do_pop) begin
            level_next = level - (PW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ready  <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            level <= level_next;
            ready <= (level_next < LVL_FULL);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/division_dispatcher.sv
// Queues operand pairs and sequences them one at a time through the external divider.
// Zero divisors are answered locally with an overflow result; a watchdog abandons stuck divides.
//
//   state | meaning
//   IDLE  | waiting for a queued pair; pops the head when one is present
//   ISSUE | start pulse to the divider (suppressed for a zero divisor)
//   WAIT  | waiting for finish, watchdog running
//   HOLD  | result presented on out_valid until out_ready
module division_dispatcher
    import fixed_point_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEFAULT,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_a,
    input  logic [WIDTH-1:0]       in_b,
    output logic [WIDTH-1:0]       div_a,
    output logic [WIDTH-1:0]       div_b,
    output logic                   div_start,
    input  logic [WIDTH-1:0]       div_result,
    input  logic                   div_overflow,
    input  logic                   div_finish,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_result,
    output logic                   out_overflow,
    output logic                   out_timeout,
    output logic [$clog2(DEPTH):0] level,
    output logic                   busy
);
    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] WD_LOAD = CW'(TIMEOUT - 1);

    state_t               state;
    state_t               state_next;
    logic [CW-1:0]        wdog;
    logic [2*WIDTH-1:0]   head;
    logic                 pop;
    logic                 b_zero;
    logic                 finish_ok;

    operand_fifo #(.WIDTH(2*WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (in_valid),
        .pop   (pop),
        .wdata ({in_a, in_b}),
        .rdata (head),
        .ready (in_ready),
        .level (level)
    );

    // The divisor is tested on the registered operand, so a zero divisor
    // spends its ISSUE cycle without pulsing start.
    assign b_zero = (div_b == '0);
    // Finish seen in the first WAIT cycle may be left over from the last divide.
    assign finish_ok = div_finish && (wdog != WD_LOAD);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (level != '0)            state_next = ST_ISSUE;
            ST_ISSUE: state_next = b_zero ? ST_HOLD : ST_WAIT;
            ST_WAIT:  if (finish_ok || wdog == '0) state_next = ST_HOLD;
            ST_HOLD:  if (out_ready)               state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        pop       = (state == ST_IDLE) && (level != '0);
        div_start = (state == ST_ISSUE) && !b_zero;
        out_valid = (state == ST_HOLD);
        busy      = (state != ST_IDLE) || (level != '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_a        <= '0;
            div_b        <= '0;
            wdog         <= '0;
            out_result   <= '0;
            out_overflow <= 1'b0;
            out_timeout  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pop) {div_a, div_b} <= head;
                end
                ST_ISSUE: begin
                    wdog <= WD_LOAD;
                    if (b_zero) begin
                        out_result   <= WIDTH'(ZERO_RESULT);
                        out_overflow <= OVF_SET;
                        out_timeout  <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (finish_ok) begin
                        out_result   <= div_result;
                        out_overflow <= div_overflow;
                        out_timeout  <= 1'b0;
                    end else if (wdog == '0) begin
                        out_result   <= WIDTH'(ZERO_RESULT);
                        out_overflow <= OVF_SET;
                        out_timeout  <= 1'b1;
                    end else begin
                        wdog <= wdog - CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_division_dispatcher.sv
// Directed bench for division_dispatcher with a Q8.8 behavioural divider of latency 24.
module tb_division_dispatcher;

    localparam int N = 24;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic [15:0] div_a;
    logic [15:0] div_b;
    logic        div_start;
    logic [15:0] div_result = '0;
    logic        div_overflow = 1'b0;
    logic        div_finish = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_result;
    logic        out_overflow;
    logic        out_timeout;
    logic [2:0]  level;
    logic        busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int start_cnt = 0;
    logic model_hang = 1'b0;

    logic [15:0] acc_res[$];
    logic        acc_ovf[$];
    int          acc_cyc[$];

    division_dispatcher #(.WIDTH(16), .DEPTH(4), .TIMEOUT(32)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .div_a(div_a), .div_b(div_b), .div_start(div_start),
        .div_result(div_result), .div_overflow(div_overflow), .div_finish(div_finish),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_overflow(out_overflow), .out_timeout(out_timeout),
        .level(level), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (div_start) start_cnt <= start_cnt + 1;
    always @(posedge clk) begin
        if (out_valid && out_ready) begin
            acc_res.push_back(out_result);
            acc_ovf.push_back(out_overflow);
            acc_cyc.push_back(cyc);
        end
    end

    // Divider model: Q8.8 quotient, saturating with overflow; never reset by the DUT.
    logic [15:0] m_a = '0;
    logic [15:0] m_b = '0;
    logic        m_run = 1'b0;
    int          m_cnt = 0;
    logic [31:0] m_q;
    assign m_q = (m_b == '0) ? 32'hFFFF_FFFF : ({16'h0, m_a} << 8) / {16'h0, m_b};

    always @(posedge clk) begin
        if (div_start) begin
            m_a        <= div_a;
            m_b        <= div_b;
            div_finish <= 1'b0;
            m_run      <= !model_hang;
            m_cnt      <= N - 1;
        end else if (m_run) begin
            if (m_cnt == 1) begin
                div_finish   <= 1'b1;
                m_run        <= 1'b0;
                div_result   <= (m_q > 32'hFFFF) ? 16'hFFFF : m_q[15:0];
                div_overflow <= (m_q > 32'hFFFF);
            end
            m_cnt <= m_cnt - 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [15:0] a, input logic [15:0] b, output int t);
        int g;
        g = 0;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        while (!in_ready && g < 300) begin
            @(negedge clk);
            g++;
        end
        @(negedge clk);
        t = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input int t0, input int budget, output int lat);
        int g;
        g = 0;
        while (!out_valid && g < budget) begin
            @(negedge clk);
            g++;
        end
        lat = out_valid ? (cyc - t0) : -1;
    endtask

    task automatic accept(output int r);
        out_ready = 1'b1;
        @(negedge clk);
        r = cyc;
        out_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "global time limit");
    end

    initial begin
        int t, t2, r, lat, s0, bad, g;

        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready",  32'(in_ready), 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_level",     32'(level), 32'h0);
        check("rst_busy",      32'(busy), 32'h0);
        check("rst_div_start", 32'(div_start), 32'h0);
        check("rst_out_ovf",   32'(out_overflow), 32'h0);
        reset = 1'b1;
        @(negedge clk);
        check("rst_release_ready", 32'(in_ready), 32'h1);

        // 1: single divide
        s0 = start_cnt;
        push(16'h0400, 16'h0200, t);
        wait_valid(t, 60, lat);
        check("t1_latency", lat, 32'd26);
        check("t1_result",  32'(out_result), 32'h0200);
        check("t1_ovf",     32'(out_overflow), 32'h0);
        check("t1_tmo",     32'(out_timeout), 32'h0);
        check("t1_starts",  start_cnt - s0, 32'd1);

        // 2: fill the FIFO behind the held result, then drain six in order
        push(16'h0100, 16'h0100, t);
        push(16'h0300, 16'h0100, t);
        push(16'h0100, 16'h0400, t);
        check("t2_ready_before_full", 32'(in_ready), 32'h1);
        push(16'h0600, 16'h0300, t);
        check("t2_level_full", 32'(level), 32'd4);
        check("t2_ready_full", 32'(in_ready), 32'h0);
        check("t2_busy",       32'(busy), 32'h1);
        in_valid = 1'b1; in_a = 16'hDEAD; in_b = 16'hBEEF;
        @(negedge clk);
        in_valid = 1'b0;
        check("t2_drop_level", 32'(level), 32'd4);
        out_ready = 1'b1;
        push(16'h7F00, 16'h0080, t);
        push(16'h4000, 16'h0040, t);
        g = 0;
        while (acc_res.size() < 7 && g < 400) begin
            @(negedge clk);
            g++;
        end
        out_ready = 1'b0;
        check("t2_count", acc_res.size(), 32'd7);
        if (acc_res.size() >= 7) begin
            check("t2_res0", 32'(acc_res[0]), 32'h0200);
            check("t2_res1", 32'(acc_res[1]), 32'h0100);
            check("t2_res2", 32'(acc_res[2]), 32'h0300);
            check("t2_res3", 32'(acc_res[3]), 32'h0040);
            check("t2_res4", 32'(acc_res[4]), 32'h0200);
            check("t2_res5", 32'(acc_res[5]), 32'hFE00);
            check("t2_res6", 32'(acc_res[6]), 32'hFFFF);
            check("t2_ovf5", 32'(acc_ovf[5]), 32'h0);
            check("t2_ovf6", 32'(acc_ovf[6]), 32'h1);
            for (int i = 1; i < 7; i++) begin
                check($sformatf("t2_spacing%0d", i), acc_cyc[i] - acc_cyc[i-1], 32'd27);
            end
        end

        // 3: divide by zero resolved locally
        s0 = start_cnt;
        push(16'h1234, 16'h0000, t);
        wait_valid(t, 20, lat);
        check("t3_latency", lat, 32'd2);
        check("t3_result",  32'(out_result), 32'h0);
        check("t3_ovf",     32'(out_overflow), 32'h1);
        check("t3_tmo",     32'(out_timeout), 32'h0);
        check("t3_starts",  start_cnt - s0, 32'd0);
        accept(r);

        // 4: watchdog timeout, then the queued pair completes
        model_hang = 1'b1;
        push(16'h0500, 16'h0100, t);
        push(16'h0100, 16'h8000, t2);
        wait_valid(t, 80, lat);
        model_hang = 1'b0;
        check("t4_latency", lat, 32'd34);
        check("t4_result",  32'(out_result), 32'h0);
        check("t4_ovf",     32'(out_overflow), 32'h1);
        check("t4_tmo",     32'(out_timeout), 32'h1);
        accept(r);
        wait_valid(r, 60, lat);
        check("t4b_latency", lat, 32'd26);
        check("t4b_result",  32'(out_result), 32'h0002);
        check("t4b_ovf",     32'(out_overflow), 32'h0);
        check("t4b_tmo",     32'(out_timeout), 32'h0);
        accept(r);

        // 5: consumer stalls for 50 cycles
        s0 = start_cnt;
        push(16'h0900, 16'h0300, t);
        wait_valid(t, 60, lat);
        check("t5_latency", lat, 32'd26);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            if (i == 3) begin
                in_valid = 1'b1; in_a = 16'h0A00; in_b = 16'h0500;
            end else begin
                in_valid = 1'b0;
            end
            if (!(out_valid === 1'b1 && out_result === 16'h0300 && out_overflow === 1'b0 &&
                  div_a === 16'h0900 && div_b === 16'h0300)) bad++;
            @(negedge clk);
        end
        check("t5_stable_bad", bad, 32'd0);
        check("t5_level_in_hold", 32'(level), 32'd1);
        check("t5_starts", start_cnt - s0, 32'd1);
        accept(r);
        wait_valid(r, 60, lat);
        check("t5b_latency", lat, 32'd26);
        check("t5b_result",  32'(out_result), 32'h0200);
        check("t5b_starts",  start_cnt - s0, 32'd2);
        accept(r);

        // 6: reset during WAIT
        push(16'h0C00, 16'h0400, t);
        repeat (8) @(negedge clk);
        reset = 1'b0;
        #1;
        check("t6_rst_start", 32'(div_start), 32'h0);
        check("t6_rst_valid", 32'(out_valid), 32'h0);
        check("t6_rst_level", 32'(level), 32'h0);
        check("t6_rst_ready", 32'(in_ready), 32'h0);
        check("t6_rst_busy",  32'(busy), 32'h0);
        check("t6_rst_diva",  32'(div_a), 32'h0);
        check("t6_rst_res",   32'(out_result), 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        s0 = start_cnt;
        g = 0;
        while (cyc < t + 32 && g < 100) begin
            @(negedge clk);
            g++;
        end
        check("t6_late_finish_valid", 32'(out_valid), 32'h0);
        check("t6_late_finish_busy",  32'(busy), 32'h0);
        check("t6_late_starts",       start_cnt - s0, 32'd0);
        push(16'h0800, 16'h0200, t);
        wait_valid(t, 60, lat);
        check("t6_next_latency", lat, 32'd26);
        check("t6_next_result",  32'(out_result), 32'h0400);
        check("t6_next_ovf",     32'(out_overflow), 32'h0);
        accept(r);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
